// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg -- shared widths and queue entry type for the fetch stage. Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// ============================================================================
// fetch_queue_ram -- DEPTH x {pc, instr} storage, split write ports, async read. Rev 1.0
// ============================================================================
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               pc_we_i,
  input  logic [AW-1:0]      pc_waddr_i,
  input  logic [ADDR_W-1:0]  pc_wdata_i,
  input  logic               instr_we_i,
  input  logic [AW-1:0]      instr_waddr_i,
  input  logic [INSTR_W-1:0] instr_wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output fetch_entry_t       rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // The PC half is written at issue, the instruction half when memory returns it.
  always_ff @(posedge clk_i) begin
    if (pc_we_i)    mem_q[pc_waddr_i].pc       <= pc_wdata_i;
    if (instr_we_i) mem_q[instr_waddr_i].instr <= instr_wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// instr_fetch_queue -- issues PCs to imem, pairs in-order responses with PCs. Rev 1.0
// ============================================================================
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  pc_in_i,
  input  logic               pc_valid_i,
  output logic               pc_ready_o,
  output logic               imem_req_valid_o,
  output logic [ADDR_W-1:0]  imem_req_addr_o,
  input  logic               imem_req_ready_i,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] discard_q, discard_d;

  logic [PW-1:0] used;
  logic [PW-1:0] outstanding;
  logic [PW:0]   occ;
  logic          space;
  logic          issue;
  logic          drop;
  logic          fill;
  logic          pop;
  logic          rsp_tracked;
  fetch_entry_t  head;

  assign used        = alloc_q - rd_q;
  assign outstanding = alloc_q - fill_q;
  // Stale responses still owed by memory keep their slots reserved.
  assign occ         = {1'b0, used} + {1'b0, discard_q};
  assign space       = occ < (PW+1)'(DEPTH);

  assign pc_ready_o       = rst_ni & imem_req_ready_i & space & ~flush_i;
  assign imem_req_valid_o = rst_ni & pc_valid_i & space & ~flush_i;
  assign imem_req_addr_o  = pc_in_i;
  assign issue            = pc_valid_i & pc_ready_o;

  assign drop        = imem_rsp_valid_i & (discard_q != '0);
  assign fill        = imem_rsp_valid_i & (discard_q == '0) & (outstanding != '0);
  assign rsp_tracked = imem_rsp_valid_i & ((discard_q != '0) | (outstanding != '0));

  assign instr_valid_o = rst_ni & (rd_q != fill_q) & ~flush_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

  always_comb begin
    alloc_d   = alloc_q + PW'(issue);
    fill_d    = fill_q + PW'(fill);
    rd_d      = rd_q + PW'(pop);
    discard_d = discard_q - PW'(drop);
    if (flush_i) begin
      alloc_d   = '0;
      fill_d    = '0;
      rd_d      = '0;
      // Everything issued but not yet answered becomes a response to throw away.
      discard_d = discard_q + outstanding - PW'(rsp_tracked);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q   <= '0;
      fill_q    <= '0;
      rd_q      <= '0;
      discard_q <= '0;
    end else begin
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      rd_q      <= rd_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i         (clk_i),
    .pc_we_i       (issue),
    .pc_waddr_i    (alloc_q[AW-1:0]),
    .pc_wdata_i    (pc_in_i),
    .instr_we_i    (fill & ~flush_i),
    .instr_waddr_i (fill_q[AW-1:0]),
    .instr_wdata_i (imem_rsp_data_i),
    .raddr_i       (rd_q[AW-1:0]),
    .rdata_o       (head)
  );

  a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> ((discard_q != '0) || (outstanding != '0)));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_queue -- directed cycle vectors for instr_fetch_queue. Rev 1.0
// ============================================================================
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .pc_in_i          (pc_in),
    .pc_valid_i       (pc_valid),
    .pc_ready_o       (pc_ready),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .instr_ready_i    (instr_ready)
  );

  typedef struct {
    logic        fl;
    logic        pv;
    logic [31:0] pc;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_pr;
    logic        e_rqv;
    logic        e_iv;
    logic [31:0] e_in;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic pv, input logic [31:0] pc,
                              input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ir, input logic e_pr, input logic e_rqv,
                              input logic e_iv, input logic [31:0] e_in,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pc = pc; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_pr = e_pr; v.e_rqv = e_rqv; v.e_iv = e_iv; v.e_in = e_in; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [31:0] xpc(input int i);
    return 32'h0000_1000 + 32'(i * 4);
  endfunction

  function automatic logic [31:0] xd(input int i);
    return ~xpc(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    flush       = v.fl;
    pc_valid    = v.pv;
    pc_in       = v.pc;
    req_ready   = v.rr;
    rsp_valid   = v.rv;
    rsp_data    = v.rd;
    instr_ready = v.ir;
    @(negedge clk);
    chk({tag, ".pc_ready"},  32'(pc_ready),    32'(v.e_pr));
    chk({tag, ".req_valid"}, 32'(req_valid),   32'(v.e_rqv));
    chk({tag, ".instr_vld"}, 32'(instr_valid), 32'(v.e_iv));
    if (v.e_rqv) chk({tag, ".req_addr"}, req_addr, v.pc);
    if (v.e_iv) begin
      chk({tag, ".instr"},    instr,    v.e_in);
      chk({tag, ".instr_pc"}, instr_pc, v.e_ipc);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  localparam int N = 20;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; pc_in = 32'h0; pc_valid = 1'b1; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = 32'h0; instr_ready = 1'b1;

    // Reset holds every handshake output low even with a valid PC offered.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc_ready",  32'(pc_ready),    32'd0);
    chk("reset.req_valid", 32'(req_valid),   32'd0);
    chk("reset.instr_vld", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;

    // Stream at latency 2, flush with two in flight, flush coinciding with a response.
    tbl.push_back(mk(0,1,32'h0,  1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h4,  1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h8,  1,1,32'h1111_0000,1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'h1111_0004,1, 1,0,1,32'h1111_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'h1111_0008,1, 1,0,1,32'h1111_0004,32'h4));
    tbl.push_back(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,1,32'h1111_0008,32'h8));
    tbl.push_back(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h10, 1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h14, 1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(1,1,32'h18, 1,0,32'h0,        1, 0,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h100,1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'hDEAD_0001,1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'hDEAD_0002,1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'hB000_0100,1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,1,32'hB000_0100,32'h100));
    tbl.push_back(mk(0,1,32'h200,1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h204,1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(1,0,32'h0,  1,1,32'hDEAD_0003,1, 0,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,1,32'h300,1,0,32'h0,        1, 1,1,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'hDEAD_0004,1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,1,32'hC000_0300,1, 1,0,0,32'h0,        32'h0));
    tbl.push_back(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,1,32'hC000_0300,32'h300));
    tbl.push_back(mk(0,1,32'h500,0,0,32'h0,        1, 0,1,0,32'h0,        32'h0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Full: four reservations with decode stalled, responses still land while full.
    apply(mk(0,1,32'h400,1,0,32'h0,        0, 1,1,0,32'h0,        32'h0),   "full0");
    apply(mk(0,1,32'h404,1,0,32'h0,        0, 1,1,0,32'h0,        32'h0),   "full1");
    apply(mk(0,1,32'h408,1,0,32'h0,        0, 1,1,0,32'h0,        32'h0),   "full2");
    apply(mk(0,1,32'h40C,1,0,32'h0,        0, 1,1,0,32'h0,        32'h0),   "full3");
    apply(mk(0,1,32'h410,1,1,32'hE000_0000,0, 0,0,0,32'h0,        32'h0),   "full4");
    apply(mk(0,1,32'h410,1,1,32'hE000_0001,1, 0,0,1,32'hE000_0000,32'h400), "full5");
    apply(mk(0,1,32'h410,1,0,32'h0,        0, 1,1,1,32'hE000_0001,32'h404), "full6");
    apply(mk(0,0,32'h0,  1,1,32'hE000_0002,1, 0,0,1,32'hE000_0001,32'h404), "full7");
    apply(mk(0,0,32'h0,  1,1,32'hE000_0003,1, 1,0,1,32'hE000_0002,32'h408), "full8");
    apply(mk(0,0,32'h0,  1,1,32'hE000_0004,1, 1,0,1,32'hE000_0003,32'h40C), "full9");
    apply(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,1,32'hE000_0004,32'h410), "full10");
    apply(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,0,32'h0,        32'h0),   "full11");

    // Issue, fill and pop together each cycle at occupancy 2 across pointer wrap.
    for (int i = 0; i < N + 2; i++) begin
      v = mk(1'b0, i < N, (i < N) ? xpc(i) : 32'h0, 1'b1,
             (i >= 1 && i <= N), (i >= 1 && i <= N) ? xd(i - 1) : 32'h0, 1'b1,
             1'b1, i < N, i >= 2,
             (i >= 2) ? xd(i - 2) : 32'h0, (i >= 2) ? xpc(i - 2) : 32'h0);
      apply(v, $sformatf("wrap%0d", i));
    end

    // Reset in the middle of traffic: outputs drop at once, pointers restart at zero.
    apply(mk(0,1,32'h600,1,0,32'h0,1, 1,1,0,32'h0,32'h0), "mid0");
    apply(mk(0,1,32'h604,1,0,32'h0,1, 1,1,0,32'h0,32'h0), "mid1");
    pc_valid = 1'b1; pc_in = 32'h608; rst_n = 1'b0;
    #1;
    chk("midrst.pc_ready",  32'(pc_ready),    32'd0);
    chk("midrst.req_valid", 32'(req_valid),   32'd0);
    chk("midrst.instr_vld", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(0,1,32'h700,1,0,32'h0,        1, 1,1,0,32'h0,        32'h0),   "post0");
    apply(mk(0,0,32'h0,  1,1,32'h0000_0077,1, 1,0,0,32'h0,        32'h0),   "post1");
    apply(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,1,32'h0000_0077,32'h700), "post2");
    apply(mk(0,0,32'h0,  1,0,32'h0,        1, 1,0,0,32'h0,        32'h0),   "post3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
